// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        ERROR = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  ACCESS_WORD      = 2'b10;
    localparam logic [1:0]  ACCESS_HALF      = 2'b01;
    localparam logic [1:0]  ACCESS_BYTE      = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;

    // Word-aligned and inside [base, base+bytes-4]; 33-bit math avoids wrap at the top.
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] bytes);
        logic [32:0] last;
        last = {1'b0, base} + bytes - 33'd4;
        return (addr[1:0] == 2'b00) && ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= last);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with hold / +4 / redirect next-pc mux
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = load_pc;
        end else if (pc_inc) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage; FETCH_RANGE_CHECK_EN adds alignment/range fault
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_in,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  insn_q, insn_d;
    logic [31:0]  insn_pc_q, insn_pc_d;
    logic         insn_valid_q, insn_valid_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  pc;
    logic         pc_inc, pc_load;
    logic         redirect_bad, capture_bad;

`ifdef FETCH_RANGE_CHECK_EN
    assign redirect_bad = !addr_ok(redirect_pc, RESET_PC, 33'(MEM_BYTES));
    assign capture_bad  = !addr_ok(pc, RESET_PC, 33'(MEM_BYTES));
    assign fetch_fault  = (state_q == ERROR);
`else
    assign redirect_bad = 1'b0;
    assign capture_bad  = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_inc  (pc_inc),
        .pc_load (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // RUN and STALL share one decision tree: a stalled stage that sees stall low captures at once.
    always_comb begin
        state_d       = state_q;
        insn_d        = insn_q;
        insn_pc_d     = insn_pc_q;
        insn_valid_d  = insn_valid_q;
        fetch_count_d = fetch_count_q;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        case (state_q)
            IDLE: begin
                insn_valid_d = 1'b0;
                if (redirect) begin
                    pc_load = 1'b1;
                end
                if (redirect && redirect_bad) begin
                    state_d = ERROR;
                end else if (fetch_en) begin
                    state_d = RUN;
                end
            end
            RUN, STALL: begin
                if (redirect) begin
                    pc_load      = 1'b1;
                    insn_valid_d = 1'b0;
                    state_d      = redirect_bad ? ERROR : RUN;
                end else if (stall) begin
                    state_d = STALL;
                end else if (!fetch_en) begin
                    insn_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (capture_bad) begin
                    insn_valid_d = 1'b0;
                    state_d      = ERROR;
                end else begin
                    insn_d        = mem_data_in;
                    insn_pc_d     = pc;
                    insn_valid_d  = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    pc_inc        = 1'b1;
                    state_d       = RUN;
                end
            end
            ERROR: begin
                insn_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            insn_q        <= 32'd0;
            insn_pc_q     <= 32'd0;
            insn_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            insn_q        <= insn_d;
            insn_pc_q     <= insn_pc_d;
            insn_valid_q  <= insn_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign mem_address     = pc;
    assign mem_write       = 1'b0;
    assign mem_access_size = ACCESS_WORD;
    assign insn            = insn_q;
    assign insn_pc         = insn_pc_q;
    assign insn_valid      = insn_valid_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, stall, redirect;
    logic [31:0] redirect_pc, mem_address, mem_data_in, insn, insn_pc, fetch_count;
    logic        mem_write, insn_valid, fetch_fault;
    logic [1:0]  mem_access_size;
    int          checks = 0;
    int          errors = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_address     (mem_address),
        .mem_write       (mem_write),
        .mem_access_size (mem_access_size),
        .mem_data_in     (mem_data_in),
        .insn            (insn),
        .insn_pc         (insn_pc),
        .insn_valid      (insn_valid),
        .fetch_count     (fetch_count),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h1111_1111;
        if (a == 32'h8002_0004) return 32'h2222_2222;
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory samples the address on the falling edge.
    always @(negedge clk) mem_data_in = mem_word(mem_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        checks++; if (mem_address !== 32'h8002_0000) begin errors++; $display("FAIL reset_pc got %h exp 80020000", mem_address); end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", insn_valid); end
        checks++; if (insn !== 32'd0 || insn_pc !== 32'd0) begin errors++; $display("FAIL reset_insn got %h/%h exp 0/0", insn, insn_pc); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        checks++; if (mem_write !== 1'b0 || mem_access_size !== 2'b10 || fetch_fault !== 1'b0) begin
            errors++; $display("FAIL reset_ties got w=%b sz=%b f=%b exp 0/10/0", mem_write, mem_access_size, fetch_fault); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        fetch_en = 1'b1;
        tick();
        checks++; if (insn_valid !== 1'b0 || mem_address !== 32'h8002_0000) begin
            errors++; $display("FAIL start_no_capture got v=%b a=%h exp 0/80020000", insn_valid, mem_address); end
        tick();
        checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'h8002_0000 || insn !== 32'h1111_1111) begin
            errors++; $display("FAIL seq_first got v=%b %h/%h exp 1 80020000/11111111", insn_valid, insn_pc, insn); end
        tick();
        checks++; if (insn_pc !== 32'h8002_0004 || insn !== 32'h2222_2222 || fetch_count !== 32'd2) begin
            errors++; $display("FAIL seq_second got %h/%h cnt=%0d exp 80020004/22222222 cnt=2", insn_pc, insn, fetch_count); end
        fetch_en = 1'b0;
        tick();
        checks++; if (insn_valid !== 1'b0 || fetch_count !== 32'd2 || mem_address !== 32'h8002_0008) begin
            errors++; $display("FAIL disable got v=%b cnt=%0d a=%h exp 0 2 80020008", insn_valid, fetch_count, mem_address); end
    endtask

    task automatic test_stall();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        fetch_en = 1'b1;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (insn !== 32'h1111_1111 || insn_pc !== 32'h8002_0000 || insn_valid !== 1'b1 || mem_address !== 32'h8002_0004) begin
                errors++; $display("FAIL stall_hold%0d got %h/%h v=%b a=%h exp 11111111/80020000 1 80020004", i, insn, insn_pc, insn_valid, mem_address); end
        end
        stall = 1'b0;
        tick();
        checks++; if (insn_pc !== 32'h8002_0004 || insn !== 32'h2222_2222 || fetch_count !== 32'd2) begin
            errors++; $display("FAIL stall_release got %h/%h cnt=%0d exp 80020004/22222222 cnt=2", insn_pc, insn, fetch_count); end
        tick();
        checks++; if (insn_pc !== 32'h8002_0008 || insn !== 32'h5EAF_BEE7 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL after_stall got %h/%h cnt=%0d exp 80020008/5eafbee7 cnt=3", insn_pc, insn, fetch_count); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h8002_0100;
        tick();
        redirect = 1'b0;
        checks++; if (insn_valid !== 1'b0 || mem_address !== 32'h8002_0100 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL redirect_bubble got v=%b a=%h cnt=%0d exp 0 80020100 3", insn_valid, mem_address, fetch_count); end
        tick();
        checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'h8002_0100 || insn !== 32'h5EAF_BFEF || fetch_count !== 32'd4) begin
            errors++; $display("FAIL redirect_target got v=%b %h/%h cnt=%0d exp 1 80020100/5eafbfef 4", insn_valid, insn_pc, insn, fetch_count); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h8002_0200;
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (mem_address !== 32'h8002_0200 || insn_valid !== 1'b0 || dut.state_q !== RUN) begin
            errors++; $display("FAIL redirect_over_stall got a=%h v=%b st=%0d exp 80020200 0 RUN", mem_address, insn_valid, dut.state_q); end
        tick();
        checks++; if (insn_pc !== 32'h8002_0200 || insn !== 32'h5EAF_BCEF || fetch_count !== 32'd5) begin
            errors++; $display("FAIL redirect_stall_target got %h/%h cnt=%0d exp 80020200/5eafbcef 5", insn_pc, insn, fetch_count); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        tick();
        checks++; if (dut.state_q !== STALL || insn_valid !== 1'b1) begin
            errors++; $display("FAIL enter_stall got st=%0d v=%b exp STALL 1", dut.state_q, insn_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (insn_valid !== 1'b0 || insn !== 32'd0 || insn_pc !== 32'd0 || fetch_count !== 32'd0 ||
                      mem_address !== 32'h8002_0000 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL async_reset got v=%b %h/%h cnt=%0d a=%h exp 0 0/0 0 80020000", insn_valid, insn, insn_pc, fetch_count, mem_address); end
        stall = 1'b0; fetch_en = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

`ifdef FETCH_RANGE_CHECK_EN
    task automatic test_range_fault();
        fetch_en = 1'b1;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h8002_0002;
        tick();
        checks++; if (fetch_fault !== 1'b1 || insn_valid !== 1'b0) begin
            errors++; $display("FAIL misalign_fault got f=%b v=%b exp 1 0", fetch_fault, insn_valid); end
        redirect_pc = 32'h8002_0000;
        tick(); tick();
        redirect = 1'b0;
        checks++; if (fetch_fault !== 1'b1 || insn_valid !== 1'b0 || mem_address !== 32'h8002_0002) begin
            errors++; $display("FAIL fault_sticky got f=%b v=%b a=%h exp 1 0 80020002", fetch_fault, insn_valid, mem_address); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
`ifdef FETCH_RANGE_CHECK_EN
        test_range_fault();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage for the pipelined processor. It sits directly upstream of the byte-addressed instruction memory. It holds the PC, drives the memory's address, write and access-size inputs for 32-bit reads, and captures the returned word into a registered instruction/PC pair for decode. It supports a decode stall and a branch/jump redirect.

Parameters:
RESET_PC, 32'h8002_0000, PC loaded on reset; equals the memory base offset.
MEM_BYTES, 1048576, size of the memory window in bytes; used only by the optional range check.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
fetch_en  in  1  start/enable; fetch proceeds only while high.
stall  in  1  decode cannot accept; hold the current instruction.
redirect  in  1  branch/jump taken; load redirect_pc.
redirect_pc  in  32  new fetch address.
mem_address  out  32  byte address to memory; equals the pc register.
mem_write  out  1  tied 0 (fetch never writes).
mem_access_size  out  2  tied 2'b10 (32-bit access).
mem_data_in  in  32  memory read data, big-endian word, passed through unmodified.
insn  out  32  captured instruction.
insn_pc  out  32  address of insn.
insn_valid  out  1  insn/insn_pc are valid for decode.
fetch_count  out  32  number of instructions delivered (insn_valid rising or advancing).
fetch_fault  out  1  range/alignment fault (feature only; else tied 0).

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, insn=0, insn_pc=0, insn_valid=0, fetch_count=0, fetch_fault=0, state=IDLE.
- Memory timing: memory samples the address and reads on the negedge, so mem_data_in is valid for pc before the next posedge. Fetch latency is 1 cycle; throughput is 1 insn/cycle.
- States are IDLE, RUN, STALL, and ERROR (ERROR exists only with the feature).
- IDLE:
  - insn_valid=0 and pc holds.
  - fetch_en=1 moves to RUN at the next posedge. No capture occurs on that edge.
- RUN, each posedge:
  - insn<=mem_data_in, insn_pc<=pc, insn_valid<=1, pc<=pc+4, fetch_count+=1.
  - If stall=1, there is no update and the state becomes STALL.
  - If fetch_en=0, insn_valid<=0 and the state becomes IDLE. The pc keeps the next address.
- STALL:
  - insn, insn_pc, insn_valid, pc and mem_address all hold.
  - The memory re-reads the same address each cycle, so no buffering is needed.
  - stall=0 returns to RUN; capture resumes on the edge where stall is seen low.
- Redirect (priority: reset > redirect > stall > normal):
  - In RUN or STALL: pc<=redirect_pc, insn_valid<=0 (one bubble), fetch_count unchanged, state becomes RUN.
  - The next edge captures the instruction at redirect_pc.
  - Redirect in IDLE loads pc only.
- PC arithmetic is modulo 2^32. redirect_pc[1:0] is not masked.
- Reset asserted mid-stall or mid-redirect returns everything to reset values immediately.
- fetch_count wraps modulo 2^32.

Optional Feature:
FETCH_RANGE_CHECK_EN
- Defined:
  - Before a capture or redirect load, the target address is checked for pc[1:0]!=0 or for falling outside [RESET_PC, RESET_PC+MEM_BYTES-4].
  - A failing check moves to ERROR with fetch_fault<=1 and insn_valid<=0. The pc holds the offending value.
  - ERROR is sticky until reset; redirect and fetch_en are ignored.
- Not defined: fetch_fault is tied 0, there is no ERROR state, and no checks are performed.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE/RUN/STALL/ERROR);
  - ACCESS_WORD=2'b10, ACCESS_HALF=2'b01, ACCESS_BYTE=2'b00;
  - the default RESET_PC constant, shared with memory.
- A single sub-module, fetch_pc_reg, is natural: it contains the pc register with the next-pc mux (hold / +4 / redirect). The rest stays in fetch_stage.

Test Plan:
- Reset then fetch_en=1; memory preloaded with 0x11111111 at 0x80020000 and 0x22222222 at 0x80020004. Required: insn_pc 0x80020000/insn 0x11111111, then 0x80020004/0x22222222 on consecutive cycles; fetch_count=2.
- Stall held 3 cycles after the first insn. Required: insn, insn_pc and mem_address frozen, and insn_valid stays 1. On release, the next insn is 0x80020004 with no skip and no duplicate.
- redirect=1 with redirect_pc=0x80020100 during RUN. Required: a one-cycle insn_valid=0 bubble, then insn_pc=0x80020100; fetch_count is not incremented for the bubble.
- redirect and stall asserted together. Required: redirect wins; pc=redirect_pc and state is RUN.
- rst_n dropped asynchronously mid-stall. Required: outputs go to reset values before the next posedge; mem_address=0x80020000.
- With FETCH_RANGE_CHECK_EN: redirect_pc=0x80020002 gives fetch_fault=1 and insn_valid=0 thereafter. A later redirect to 0x80020000 is ignored until reset.
